// File: rtl/hash_request_streamer_if.sv
// hash_request_streamer_if: command, request-stream, response-snoop and status bundle.
// The streamer sits on the master side; the table/environment sits on the slave side.
interface hash_request_streamer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [1:0]            cmd_op_i;
    logic [DATA_WIDTH-1:0] cmd_key_i;
    logic [DATA_WIDTH-1:0] cmd_value_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_o;
    logic [7:0]            keep_o;
    logic                  rsp_valid_i;
    logic                  rsp_ready_i;
    logic                  rsp_last_i;
    logic [7:0]            outstanding_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_key_i, cmd_value_i, ready_i,
               rsp_valid_i, rsp_ready_i, rsp_last_i,
        output cmd_ready_o, data_o, valid_o, last_o, keep_o,
               outstanding_o, busy_o, err_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_key_i, cmd_value_i, ready_i,
               rsp_valid_i, rsp_ready_i, rsp_last_i,
        input  cmd_ready_o, data_o, valid_o, last_o, keep_o,
               outstanding_o, busy_o, err_o
    );
endinterface

// File: rtl/hash_request_streamer.sv
// hash_request_streamer: serializes table ops into header/key/value stream beats
// and tracks in-flight requests by snooping the response stream.
module hash_request_streamer #(
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    hash_request_streamer_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_KEY  = 2'd2;
    localparam logic [1:0] S_VAL  = 2'd3;
    localparam logic [1:0] OP_INS = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_key;
    logic [DATA_WIDTH-1:0] r_val;
    logic [DATA_WIDTH-1:0] r_data;
    logic [7:0]            r_tag;
    logic [7:0]            r_outstanding;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_err;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_inc;
    logic                  w_dec;

    assign w_ready  = (r_state == S_IDLE) && (r_outstanding < 8'(MAX_OUTSTANDING));
    assign w_accept = w_ready && bus.cmd_valid_i;
    assign w_beat   = r_valid && bus.ready_i;
    assign w_inc    = w_beat && r_last;
    assign w_dec    = bus.rsp_valid_i && bus.rsp_ready_i && bus.rsp_last_i;

    assign bus.cmd_ready_o   = w_ready;
    assign bus.data_o        = r_data;
    assign bus.valid_o       = r_valid;
    assign bus.last_o        = r_last;
    assign bus.keep_o        = r_valid ? 8'hFF : 8'h00;
    assign bus.outstanding_o = r_outstanding;
    assign bus.busy_o        = r_state != S_IDLE;
    assign bus.err_o         = r_err;

    // Beat registers only advance on handshake, so data/last hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'd0;
            r_key   <= '0;
            r_val   <= '0;
            r_data  <= '0;
            r_tag   <= 8'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state <= S_HDR;
                    r_op    <= bus.cmd_op_i;
                    r_key   <= bus.cmd_key_i;
                    r_val   <= bus.cmd_value_i;
                    r_tag   <= r_tag + 8'd1;
                    r_valid <= 1'b1;
                    r_last  <= bus.cmd_op_i == OP_CLR;
                    r_data  <= {bus.cmd_op_i, r_tag, {(DATA_WIDTH-10){1'b0}}};
                end
                S_HDR: if (w_beat) begin
                    r_state <= (r_op == OP_CLR) ? S_IDLE : S_KEY;
                    r_valid <= r_op != OP_CLR;
                    r_last  <= (r_op != OP_CLR) && (r_op != OP_INS);
                    r_data  <= r_key;
                end
                S_KEY: if (w_beat) begin
                    r_state <= (r_op == OP_INS) ? S_VAL : S_IDLE;
                    r_valid <= r_op == OP_INS;
                    r_last  <= r_op == OP_INS;
                    r_data  <= r_val;
                end
                default: if (w_beat) begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= 8'd0;
            r_err         <= 1'b0;
        end else if (w_inc && !w_dec) begin
            r_outstanding <= r_outstanding + 8'd1;
        end else if (w_dec && !w_inc) begin
            r_outstanding <= (r_outstanding == 8'd0) ? 8'd0 : r_outstanding - 8'd1;
            r_err         <= r_err || (r_outstanding == 8'd0);
        end
    end
endmodule

// File: tb/tb_hash_request_streamer.sv
// tb_hash_request_streamer: directed checks of beat framing, stalls, in-flight limit,
// response underflow, tag wrap and asynchronous reset.
module tb_hash_request_streamer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    hash_request_streamer_if #(.DATA_WIDTH(64)) bus ();

    hash_request_streamer #(
        .DATA_WIDTH(64),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [1:0] op, input logic [7:0] tag);
        return {op, tag, 54'd0};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [63:0] key, input logic [63:0] val);
        int t;
        t = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_key_i   = key;
        bus.cmd_value_i = val;
        while (!bus.cmd_ready_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("cmd_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic finish_req();
        int t;
        t = 0;
        while (bus.valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic rsp();
        bus.rsp_valid_i = 1'b1;
        bus.rsp_ready_i = 1'b1;
        bus.rsp_last_i  = 1'b1;
        @(negedge clk);
        bus.rsp_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.rsp_last_i  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'd0;
        bus.cmd_key_i   = 64'd0;
        bus.cmd_value_i = 64'd0;
        bus.ready_i     = 1'b1;
        bus.rsp_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.rsp_last_i  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_keep", bus.keep_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_outstanding", bus.outstanding_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready_o, 1);

        issue(2'd1, 64'h1111, 64'h2222);
        chk("ins_hdr", bus.data_o, 64'h4000_0000_0000_0000);
        chk("ins_hdr_valid", bus.valid_o, 1);
        chk("ins_hdr_last", bus.last_o, 0);
        chk("ins_hdr_keep", bus.keep_o, 64'hFF);
        chk("ins_busy", bus.busy_o, 1);
        chk("ins_ready_busy", bus.cmd_ready_o, 0);
        @(negedge clk);
        chk("ins_key", bus.data_o, 64'h1111);
        chk("ins_key_last", bus.last_o, 0);
        @(negedge clk);
        chk("ins_val", bus.data_o, 64'h2222);
        chk("ins_val_last", bus.last_o, 1);
        chk("ins_val_keep", bus.keep_o, 64'hFF);
        @(negedge clk);
        chk("ins_done_valid", bus.valid_o, 0);
        chk("ins_done_keep", bus.keep_o, 0);
        chk("ins_done_last", bus.last_o, 0);
        chk("ins_outstanding", bus.outstanding_o, 1);
        chk("ins_cmd_ready", bus.cmd_ready_o, 1);
        rsp();
        chk("ins_rsp_outstanding", bus.outstanding_o, 0);

        issue(2'd0, 64'hABCD, 64'h9999);
        chk("lk_hdr", bus.data_o, 64'h0040_0000_0000_0000);
        chk("lk_hdr_last", bus.last_o, 0);
        @(negedge clk);
        chk("lk_key", bus.data_o, 64'hABCD);
        chk("lk_key_last", bus.last_o, 1);
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lk_stall_data", bus.data_o, 64'hABCD);
            chk("lk_stall_valid", bus.valid_o, 1);
            chk("lk_stall_last", bus.last_o, 1);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("lk_done_valid", bus.valid_o, 0);
        chk("lk_outstanding", bus.outstanding_o, 1);
        rsp();

        issue(2'd3, 64'h7777, 64'h8888);
        chk("clr_hdr", bus.data_o, 64'hC080_0000_0000_0000);
        chk("clr_last", bus.last_o, 1);
        @(negedge clk);
        chk("clr_done_valid", bus.valid_o, 0);
        chk("clr_outstanding", bus.outstanding_o, 1);
        rsp();
        chk("clr_rsp_outstanding", bus.outstanding_o, 0);

        issue(2'd0, 64'd1, 64'd0);
        finish_req();
        issue(2'd0, 64'd2, 64'd0);
        finish_req();
        chk("max_outstanding", bus.outstanding_o, 2);
        chk("max_cmd_ready", bus.cmd_ready_o, 0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 2'd0;
        bus.cmd_key_i   = 64'd3;
        repeat (3) @(negedge clk);
        chk("max_stall_ready", bus.cmd_ready_o, 0);
        chk("max_stall_busy", bus.busy_o, 0);
        chk("max_stall_valid", bus.valid_o, 0);
        rsp();
        chk("max_rsp_outstanding", bus.outstanding_o, 1);
        chk("max_rsp_ready", bus.cmd_ready_o, 1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk("max_third_valid", bus.valid_o, 1);
        chk("max_third_hdr", bus.data_o, 64'h0140_0000_0000_0000);
        @(negedge clk);
        chk("max_third_key", bus.data_o, 64'd3);
        rsp();
        chk("both_outstanding", bus.outstanding_o, 1);
        chk("both_valid", bus.valid_o, 0);
        chk("both_err", bus.err_o, 0);
        rsp();
        chk("drain_outstanding", bus.outstanding_o, 0);
        chk("drain_err", bus.err_o, 0);
        rsp();
        chk("under_outstanding", bus.outstanding_o, 0);
        chk("under_err", bus.err_o, 1);
        repeat (3) @(negedge clk);
        chk("under_err_sticky", bus.err_o, 1);

        issue(2'd1, 64'h55, 64'h66);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_val", bus.data_o, 64'h66);
        chk("rstmid_valid_pre", bus.valid_o, 1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_valid", bus.valid_o, 0);
        chk("rstmid_keep", bus.keep_o, 0);
        chk("rstmid_last", bus.last_o, 0);
        chk("rstmid_data", bus.data_o, 0);
        chk("rstmid_busy", bus.busy_o, 0);
        chk("rstmid_err", bus.err_o, 0);
        chk("rstmid_outstanding", bus.outstanding_o, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 257; i++) begin
            issue(2'd3, 64'd0, 64'd0);
            chk("tag_hdr", bus.data_o, hdr(2'd3, 8'(i)));
            @(negedge clk);
            rsp();
        end
        chk("tag_end_outstanding", bus.outstanding_o, 0);
        chk("tag_end_err", bus.err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
